accel_lite_arbiter: RTL and testbench



---
 rtl/accel_lite_arb_pkg.sv | 22 ++
 rtl/accel_lite_rr_arb.sv | 42 ++++
 rtl/accel_lite_arbiter.sv | 151 +++++++++++++++
 tb/tb_accel_lite_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_lite_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite arbiter/sequencer.
// Build option ACCEL_ARB_FIXED_PRIO_EN selects fixed priority in accel_lite_rr_arb.
package accel_lite_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] AXI_WSTRB = 4'hF;
  localparam logic [2:0] AXI_PROT  = 3'b000;

endpackage

// File: rtl/accel_lite_rr_arb.sv
// Two-way request arbiter: combinational grant, registered round-robin favour bit.
// With ACCEL_ARB_FIXED_PRIO_EN defined, requester 0 always wins and the favour bit is removed.
module accel_lite_rr_arb
  import accel_lite_arb_pkg::*;
(
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  input  logic               upd_idx,
  output logic               gnt_valid,
  output logic               gnt_idx
);

  assign gnt_valid = |req;

`ifdef ACCEL_ARB_FIXED_PRIO_EN
  assign gnt_idx = ~req[0];
`else
  logic favour;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      favour <= 1'b0;
    end else if (update) begin
      favour <= ~upd_idx;
    end
  end

  // NOTE: default first so every path assigns gnt_idx and no latch is inferred.
  always_comb begin
    gnt_idx = favour;
    if (req == 2'b01) begin
      gnt_idx = 1'b0;
    end else if (req == 2'b10) begin
      gnt_idx = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/accel_lite_arbiter.sv
// Grants one of two requesters and runs a single AXI4-Lite transaction as master on its behalf.
// Tie-break policy is round-robin unless ACCEL_ARB_FIXED_PRIO_EN is defined.
module accel_lite_arbiter
  import accel_lite_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [1:0]                    resp,
  output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [DATA_WIDTH-1:0]         m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  // Registers are word-aligned; the byte offset is always driven as zero.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);

  state_t                  state;
  logic                    grant_q;
  logic                    we_q;
  logic                    gnt_valid;
  logic                    gnt_idx;
  logic                    we_sel;
  logic [ADDR_WIDTH-1:0]   addr_sel;
  logic [DATA_WIDTH-1:0]   wdata_sel;
  logic                    aw_done;
  logic                    w_done;

  assign m_axi_awprot = AXI_PROT;
  assign m_axi_arprot = AXI_PROT;
  assign m_axi_wstrb  = AXI_WSTRB;

  accel_lite_rr_arb u_arb (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .req       (req),
    .update    (state == DONE),
    .upd_idx   (grant_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    we_sel    = we[0];
    addr_sel  = addr[ADDR_WIDTH-1:0];
    wdata_sel = wdata[DATA_WIDTH-1:0];
    if (gnt_idx) begin
      we_sel    = we[1];
      addr_sel  = addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
      wdata_sel = wdata[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  // A write channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done = !m_axi_awvalid || m_axi_awready;
  assign w_done  = !m_axi_wvalid  || m_axi_wready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      grant_q       <= 1'b0;
      we_q          <= 1'b0;
      ack           <= '0;
      rdata         <= '0;
      resp          <= RESP_OKAY;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            grant_q       <= gnt_idx;
            we_q          <= we_sel;
            m_axi_awaddr  <= addr_sel & ADDR_MASK;
            m_axi_araddr  <= addr_sel & ADDR_MASK;
            m_axi_wdata   <= wdata_sel;
            m_axi_awvalid <= we_sel;
            m_axi_wvalid  <= we_sel;
            m_axi_arvalid <= !we_sel;
            state         <= ADDR;
          end
        end
        ADDR: begin
          if (we_q) begin
            if (m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
            if (aw_done && w_done) begin
              m_axi_bready <= 1'b1;
              state        <= RESP;
            end
          end else if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (we_q && m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            resp         <= m_axi_bresp;
            rdata        <= '0;
            ack          <= NUM_REQ'(1) << grant_q;
            state        <= DONE;
          end else if (!we_q && m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            resp         <= m_axi_rresp;
            rdata        <= m_axi_rdata;
            ack          <= NUM_REQ'(1) << grant_q;
            state        <= DONE;
          end
        end
        DONE: begin
          ack   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_lite_arbiter.sv
// Randomized bench for accel_lite_arbiter: AXI4-Lite slave with stalls, two requester drivers,
// and a register/arbitration reference model. Honours ACCEL_ARB_FIXED_PRIO_EN for grant order.
module tb_accel_lite_arbiter;
  import accel_lite_arb_pkg::*;

  localparam int OPS_MAX   = 32;
  localparam int OP_BUDGET = 300;

  typedef struct {
    bit          w;
    logic [1:0]  reg_idx;
    logic [1:0]  low;
    logic [31:0] data;
    int          gap;
  } op_t;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [1:0]  req, we, ack, resp;
  logic [7:0]  addr;
  logic [63:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  m_axi_awaddr, m_axi_araddr, m_axi_wstrb;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready;
  logic [31:0] m_axi_wdata;
  logic        m_axi_awready = 0, m_axi_wready = 0, m_axi_arready = 0;
  logic        m_axi_bvalid = 0, m_axi_rvalid = 0;
  logic [1:0]  m_axi_bresp = 0, m_axi_rresp = 0;
  logic [31:0] m_axi_rdata = 0;

  logic        req_a   [2];
  logic        we_a    [2];
  logic [3:0]  addr_a  [2];
  logic [31:0] wdata_a [2];

  assign req   = {req_a[1], req_a[0]};
  assign we    = {we_a[1], we_a[0]};
  assign addr  = {addr_a[1], addr_a[0]};
  assign wdata = {wdata_a[1], wdata_a[0]};

  always #5 ACLK = ~ACLK;

  accel_lite_arbiter dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .resp(resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Slave configuration and observation counters
  logic [31:0] mem [4] = '{default: 0};
  int  cfg_aw = 0, cfg_w = 0, cfg_ar = 0, cfg_b = 0, cfg_r = 0;
  bit  rand_dly = 0;
  logic [1:0] cfg_bresp = 0, cfg_rresp = 0;
  int  aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0, viol = 0;
  int  ack_cnt [2] = '{0, 0};

  // Reference model state
  logic [31:0] ref_mem [4] = '{default: 0};
  logic [1:0]  exp_resp = RESP_OKAY;
  op_t ops [2][OPS_MAX];
  int  nops [2] = '{0, 0};
  int  done_cnt [2] = '{0, 0};
  int  last_lat [2] = '{0, 0};
  int  got_order [$];

  function automatic int pick(input int c);
    return rand_dly ? int'($urandom_range(5, 0)) : c;
  endfunction

  function automatic op_t mk(input bit w, input int idx, input int low, input logic [31:0] d,
                             input int gap);
    op_t o;
    o.w = w; o.reg_idx = 2'(idx); o.low = 2'(low); o.data = d; o.gap = gap;
    return o;
  endfunction

  // AXI4-Lite slave: acts at negedges, infers the handshakes of the preceding posedge.
  initial begin
    bit aw_got = 0, w_got = 0, ar_got = 0, b_pend = 0, r_pend = 0;
    int aw_wait = -1, w_wait = -1, ar_wait = -1, b_wait = 0, r_wait = 0;
    logic s_awv = 0, s_wv = 0, s_arv = 0, s_bready = 0, s_rready = 0;
    logic [3:0] s_awaddr = 0, s_araddr = 0, got_awaddr = 0, got_araddr = 0;
    logic [31:0] s_wdata = 0, got_wdata = 0, r_hold = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
        aw_wait = -1; w_wait = -1; ar_wait = -1;
        s_awv = 0; s_wv = 0; s_arv = 0; s_bready = 0; s_rready = 0;
      end else begin
        if (ack[0]) ack_cnt[0]++;
        if (ack[1]) ack_cnt[1]++;
        if (ack == 2'b11) viol++;
        if (s_awv) begin
          if (m_axi_awready) begin
            aw_hs++; aw_got = 1; got_awaddr = s_awaddr; m_axi_awready = 0; aw_wait = -1;
            if (s_awaddr[1:0] != 0) viol++;
          end else if (!m_axi_awvalid || m_axi_awaddr !== s_awaddr) viol++;
        end
        if (s_wv) begin
          if (m_axi_wready) begin
            w_hs++; w_got = 1; got_wdata = s_wdata; m_axi_wready = 0; w_wait = -1;
          end else if (!m_axi_wvalid || m_axi_wdata !== s_wdata) viol++;
        end
        if (s_arv) begin
          if (m_axi_arready) begin
            ar_hs++; ar_got = 1; got_araddr = s_araddr; m_axi_arready = 0; ar_wait = -1;
            if (s_araddr[1:0] != 0) viol++;
          end else if (!m_axi_arvalid || m_axi_araddr !== s_araddr) viol++;
        end
        if (m_axi_bvalid && s_bready) begin b_hs++; m_axi_bvalid = 0; b_pend = 0; end
        if (m_axi_rvalid && s_rready) begin r_hs++; m_axi_rvalid = 0; r_pend = 0; end
        if (aw_got && w_got) begin
          mem[got_awaddr[3:2]] = got_wdata;
          aw_got = 0; w_got = 0; b_pend = 1; b_wait = pick(cfg_b);
        end
        if (ar_got) begin
          ar_got = 0; r_pend = 1; r_wait = pick(cfg_r); r_hold = mem[got_araddr[3:2]];
        end
        if (m_axi_awvalid && !aw_got && !m_axi_awready) begin
          if (aw_wait < 0) aw_wait = pick(cfg_aw);
          if (aw_wait == 0) m_axi_awready = 1; else aw_wait--;
        end
        if (m_axi_wvalid && !w_got && !m_axi_wready) begin
          if (w_wait < 0) w_wait = pick(cfg_w);
          if (w_wait == 0) m_axi_wready = 1; else w_wait--;
        end
        if (m_axi_arvalid && !ar_got && !m_axi_arready) begin
          if (ar_wait < 0) ar_wait = pick(cfg_ar);
          if (ar_wait == 0) m_axi_arready = 1; else ar_wait--;
        end
        if (b_pend && !m_axi_bvalid) begin
          if (b_wait == 0) begin m_axi_bvalid = 1; m_axi_bresp = cfg_bresp; end
          else b_wait--;
        end
        if (r_pend && !m_axi_rvalid) begin
          if (r_wait == 0) begin
            m_axi_rvalid = 1; m_axi_rdata = r_hold; m_axi_rresp = cfg_rresp;
          end else r_wait--;
        end
        s_awv = m_axi_awvalid; s_awaddr = m_axi_awaddr;
        s_wv  = m_axi_wvalid;  s_wdata  = m_axi_wdata;
        s_arv = m_axi_arvalid; s_araddr = m_axi_araddr;
        s_bready = m_axi_bready; s_rready = m_axi_rready;
      end
    end
  end

  // Presents requester r's op list, one request at a time, and checks each ack against the model.
  task automatic drive(input int r);
    op_t op;
    int  waited;
    bit  got;
    for (int i = 0; i < nops[r]; i++) begin
      op = ops[r][i];
      if (op.gap > 0) begin
        req_a[r] = 0;
        repeat (op.gap) @(negedge ACLK);
      end
      req_a[r] = 1; we_a[r] = op.w; addr_a[r] = {op.reg_idx, op.low}; wdata_a[r] = op.data;
      waited = 1;
      got = 0;
      while (!got && waited < OP_BUDGET) begin
        @(negedge ACLK);
        waited++;
        if (ack[r]) got = 1;
      end
      check($sformatf("ack_seen_r%0d", r), 32'(got), 32'd1);
      if (!got) begin
        req_a[r] = 0;
        return;
      end
      last_lat[r] = waited;
      got_order.push_back(r);
      if (op.w) begin
        ref_mem[op.reg_idx] = op.data;
        check($sformatf("wr_rdata_r%0d", r), rdata, 32'd0);
      end else begin
        check($sformatf("rd_data_r%0d_reg%0d", r, op.reg_idx), rdata, ref_mem[op.reg_idx]);
      end
      check($sformatf("resp_r%0d", r), 32'(resp), 32'(exp_resp));
      done_cnt[r]++;
    end
    req_a[r] = 0;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_ack"}, 32'(ack), 32'd0);
    check({pfx, "_rdata"}, rdata, 32'd0);
    check({pfx, "_resp"}, 32'(resp), 32'd0);
    check({pfx, "_valids"}, 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 32'd0);
    check({pfx, "_readys"}, 32'({m_axi_bready, m_axi_rready}), 32'd0);
    check({pfx, "_awaddr"}, 32'(m_axi_awaddr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, w0, b0, ar0, r0, nwr, nrd, acks_before, seen;
    int rem [2];
    int last, win;
    for (int r = 0; r < 2; r++) begin
      req_a[r] = 0; we_a[r] = 0; addr_a[r] = 0; wdata_a[r] = 0;
    end
    ARESETN = 0;
    repeat (3) @(negedge ACLK);
    #1 check_idle_outputs("reset");
    check("wstrb", 32'(m_axi_wstrb), 32'hF);
    check("prot", 32'({m_axi_awprot, m_axi_arprot}), 32'd0);
    @(negedge ACLK); #2 ARESETN = 1;

    // Single write: AW ready two cycles ahead of W, then readback with zero stalls
    cfg_aw = 0; cfg_w = 2; cfg_b = 0;
    a0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs;
    ops[0][0] = mk(1, 0, 0, 32'h0000_0001, 0); nops[0] = 1;
    @(negedge ACLK); drive(0);
    check("single_aw_hs", 32'(aw_hs - a0), 32'd1);
    check("single_w_hs", 32'(w_hs - w0), 32'd1);
    check("single_b_hs", 32'(b_hs - b0), 32'd1);
    check("single_ar_hs", 32'(ar_hs - ar0), 32'd0);
    cfg_w = 0;
    ops[0][0] = mk(0, 0, 0, 32'h0, 2); nops[0] = 1;
    @(negedge ACLK); drive(0);
    check("min_latency_cycles", 32'(last_lat[0]), 32'd4);

    // Sequential registers via requester 1, with junk in the ignored byte-offset bits
    for (int i = 0; i < 4; i++) ops[1][i] = mk(1, i, i, 32'(i + 1), 0);
    for (int i = 0; i < 4; i++) ops[1][4 + i] = mk(0, i, 3 - i, 32'h0, 0);
    nops[1] = 8;
    @(negedge ACLK); drive(1);

    // Contention: both requesters hold req for four transactions each
    rand_dly = 1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) ops[r][i] = mk(1'($urandom), $urandom_range(3, 0), 0, $urandom, 0);
      nops[r] = 4;
    end
    got_order.delete();
    @(negedge ACLK);
    fork
      drive(0);
      drive(1);
    join
    check("order_len", 32'(got_order.size()), 32'd8);
    rem[0] = 4; rem[1] = 4; last = 1;
    for (int k = 0; k < 8 && k < got_order.size(); k++) begin
      if (rem[0] > 0 && rem[1] > 0) begin
`ifdef ACCEL_ARB_FIXED_PRIO_EN
        win = 0;
`else
        win = 1 - last;
`endif
      end else begin
        win = (rem[0] > 0) ? 0 : 1;
      end
      rem[win]--;
      last = win;
      check($sformatf("grant_order_%0d", k), 32'(got_order[k]), 32'(win));
    end

    // Error pass-through, followed by a clean transaction
    rand_dly = 0;
    cfg_rresp = RESP_SLVERR; exp_resp = RESP_SLVERR;
    ops[0][0] = mk(0, 2, 0, 32'h0, 1); nops[0] = 1;
    @(negedge ACLK); drive(0);
    cfg_rresp = RESP_OKAY; exp_resp = RESP_OKAY;
    @(negedge ACLK); drive(0);
    cfg_bresp = RESP_DECERR; exp_resp = RESP_DECERR;
    ops[0][0] = mk(1, 3, 0, 32'hA5A5_0003, 1);
    @(negedge ACLK); drive(0);
    cfg_bresp = RESP_OKAY; exp_resp = RESP_OKAY;

    // Reset while AW is stalled: outputs clear at once and the write is never acknowledged
    cfg_aw = 50;
    acks_before = ack_cnt[0] + ack_cnt[1];
    @(negedge ACLK);
    req_a[0] = 1; we_a[0] = 1; addr_a[0] = 4'h4; wdata_a[0] = 32'hDEAD_BEEF;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ACLK);
      if (m_axi_awvalid) seen = 1;
    end
    check("rst_mid_aw_seen", 32'(seen), 32'd1);
    @(posedge ACLK); #2 ARESETN = 0;
    #1 check_idle_outputs("rst_mid");
    req_a[0] = 0;
    repeat (3) @(negedge ACLK);
    #2 ARESETN = 1;
    cfg_aw = 0;
    ops[0][0] = mk(0, 1, 0, 32'h0, 1); nops[0] = 1;
    @(negedge ACLK); drive(0);
    check("rst_mid_no_ack", 32'(ack_cnt[0] + ack_cnt[1] - acks_before), 32'd1);

    // Random traffic from both requesters with random stalls on every channel
    rand_dly = 1;
    nwr = 0; nrd = 0;
    for (int r = 0; r < 2; r++) begin
      nops[r] = 20;
      for (int i = 0; i < 20; i++) begin
        ops[r][i] = mk(1'($urandom), $urandom_range(3, 0), $urandom_range(3, 0), $urandom,
                       $urandom_range(3, 0));
        if (ops[r][i].w) nwr++; else nrd++;
      end
    end
    a0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
    @(negedge ACLK);
    fork
      drive(0);
      drive(1);
    join
    repeat (3) @(negedge ACLK);
    check("rand_aw_hs", 32'(aw_hs - a0), 32'(nwr));
    check("rand_w_hs", 32'(w_hs - w0), 32'(nwr));
    check("rand_b_hs", 32'(b_hs - b0), 32'(nwr));
    check("rand_ar_hs", 32'(ar_hs - ar0), 32'(nrd));
    check("rand_r_hs", 32'(r_hs - r0), 32'(nrd));

    check("protocol_violations", 32'(viol), 32'd0);
    check("ack_count_r0", 32'(ack_cnt[0]), 32'(done_cnt[0]));
    check("ack_count_r1", 32'(ack_cnt[1]), 32'(done_cnt[1]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
